// File: rtl/nf_seq_control_unit_pkg.sv
// ============================================================================
// nf_seq_control_unit_pkg : control bundle, sequencer states, decode constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package nf_seq_control_unit_pkg;

  typedef struct packed {
    logic [4:0] imm_src;
    logic [1:0] srcA_sel;
    logic       srcB_sel;
    logic [1:0] shift_sel;
    logic       res_sel;
    logic [3:0] branch_type;
    logic       branch_hf;
    logic       branch_src;
    logic       we_rf;
    logic       we_dm;
    logic       rf_src;
    logic [1:0] size_dm;
    logic       sign_dm;
    logic [1:0] csr_cmd;
    logic       csr_rreq;
    logic       csr_wreq;
    logic       csr_sel;
    logic [3:0] alu_code;
    logic       is_mem;
    logic       is_md;
  } nf_ctrl_t;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, MD = 2'd2} seq_state_e;

  localparam logic [6:0] M_OP      = 7'b0000001;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [4:0] IMM_I = 5'b00001;
  localparam logic [4:0] IMM_U = 5'b00010;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_S = 5'b01000;
  localparam logic [4:0] IMM_J = 5'b10000;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [3:0] BR_EQ   = 4'b0001;
  localparam logic [3:0] BR_LT   = 4'b0010;
  localparam logic [3:0] BR_LTU  = 4'b0100;
  localparam logic [3:0] BR_JUMP = 4'b1000;

  localparam logic RF_ALUR = 1'b0;
  localparam logic RF_DMEM = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;

  // alt is funct7[5]; it selects SUB only for R-type but SRA for both R and I.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  alu_op = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/nf_seq_control_unit_decode.sv
// ============================================================================
// nf_ctrl_decode : combinational RV32I(+M) instruction to control-bundle map
// Revision: 1.0
// ============================================================================
`default_nettype none

module nf_ctrl_decode
  import nf_seq_control_unit_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [31:0] instr,
  output nf_ctrl_t    ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       rd_nz;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign f3            = instr[14:12];
  assign f7            = instr[31:25];
  assign rd_nz         = |instr[11:7];
  assign unused_fields = ^instr[24:15];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.we_rf = 1'b1;
        if (f7 == M_OP) begin
          if (M_EXT != 0) ctrl.is_md = 1'b1;
          else            illegal    = 1'b1;
        end else begin
          ctrl.alu_code = alu_op(f3, f7[5], 1'b1);
        end
      end
      OP_IMM: begin
        ctrl.imm_src   = IMM_I;
        ctrl.srcB_sel  = 1'b1;
        ctrl.we_rf     = 1'b1;
        ctrl.shift_sel = (f3[1:0] == 2'b01) ? 2'd1 : 2'd0;
        ctrl.alu_code  = alu_op(f3, f7[5], 1'b0);
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.imm_src  = IMM_U;
        ctrl.srcA_sel = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_PC;
        ctrl.srcB_sel = 1'b1;
        ctrl.we_rf    = 1'b1;
        ctrl.alu_code = ALU_ADD;
      end
      OP_JAL, OP_JALR: begin
        ctrl.imm_src     = (opcode == OP_JAL) ? IMM_J : IMM_I;
        ctrl.branch_type = BR_JUMP;
        ctrl.branch_src  = (opcode == OP_JALR);
        ctrl.res_sel     = 1'b1;
        ctrl.we_rf       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.imm_src     = IMM_B;
        ctrl.branch_hf   = f3[0];
        ctrl.alu_code    = ALU_SUB;
        ctrl.branch_type = !f3[2] ? BR_EQ : (f3[1] ? BR_LTU : BR_LT);
      end
      OP_LOAD, OP_STORE: begin
        ctrl.imm_src  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        ctrl.srcB_sel = 1'b1;
        ctrl.alu_code = ALU_ADD;
        ctrl.we_rf    = (opcode == OP_LOAD);
        ctrl.we_dm    = (opcode == OP_STORE);
        ctrl.rf_src   = (opcode == OP_LOAD) ? RF_DMEM : RF_ALUR;
        ctrl.size_dm  = f3[1:0];
        ctrl.sign_dm  = ~f3[2];
        ctrl.is_mem   = 1'b1;
      end
      OP_SYSTEM: begin
        ctrl.csr_cmd  = f3[1:0];
        ctrl.csr_sel  = f3[2];
        ctrl.csr_rreq = rd_nz;
        ctrl.we_rf    = rd_nz;
        ctrl.csr_wreq = |f3;
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    // An illegal word must never write state or start a sequence.
    if (illegal) begin
      ctrl.we_rf  = 1'b0;
      ctrl.we_dm  = 1'b0;
      ctrl.is_mem = 1'b0;
      ctrl.is_md  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nf_seq_control_unit.sv
// ============================================================================
// nf_seq_control_unit : decode + sequencer for single-cycle, MEM and MD classes
// Revision: 1.0
// ============================================================================
`default_nettype none

module nf_seq_control_unit
  import nf_seq_control_unit_pkg::*;
#(
  parameter int M_EXT   = 1,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output nf_ctrl_t    ctrl,
  output logic        ctrl_valid,
  output logic        illegal_instr,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [1:0]  dm_size,
  input  logic        dm_ack,
  output logic        md_start,
  output logic [2:0]  md_op,
  input  logic        md_done
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  seq_state_e      state, state_n;
  logic [TO_W-1:0] cnt, cnt_n;
  nf_ctrl_t        dec_ctrl, ctrl_n;
  logic            dec_ill;
  logic            cv_n, ill_n, berr_n, req_n, we_n, start_n, expired;
  logic [1:0]      size_n;
  logic [2:0]      op_n;

  nf_ctrl_decode #(.M_EXT(M_EXT)) u_decode (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill)
  );

  assign instr_ready = (state == IDLE);
  assign expired     = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ctrl_n  = ctrl;
    cv_n    = 1'b0;
    ill_n   = 1'b0;
    berr_n  = 1'b0;
    req_n   = dm_req;
    we_n    = dm_we;
    size_n  = dm_size;
    start_n = 1'b0;
    op_n    = md_op;
    case (state)
      IDLE: begin
        if (instr_valid && !flush) begin
          ctrl_n = dec_ctrl;
          if (dec_ill) begin
            ill_n = 1'b1;
          end else if (dec_ctrl.is_mem) begin
            state_n = MEM;
            req_n   = 1'b1;
            we_n    = dec_ctrl.we_dm;
            size_n  = instr[13:12];
            cnt_n   = '0;
          end else if (dec_ctrl.is_md) begin
            state_n = MD;
            start_n = 1'b1;
            op_n    = instr[14:12];
            cnt_n   = '0;
          end else begin
            cv_n = 1'b1;
          end
        end
      end
      MEM, MD: begin
        // A completion arriving on the expiry cycle takes priority over the timeout.
        if ((state == MEM) ? dm_ack : md_done) begin
          state_n = IDLE;
          req_n   = 1'b0;
          cv_n    = 1'b1;
        end else if (expired) begin
          state_n = IDLE;
          req_n   = 1'b0;
          berr_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      req_n   = 1'b0;
      cv_n    = 1'b0;
      ill_n   = 1'b0;
      berr_n  = 1'b0;
      start_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      ctrl          <= '0;
      ctrl_valid    <= 1'b0;
      illegal_instr <= 1'b0;
      bus_err       <= 1'b0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_size       <= 2'b00;
      md_start      <= 1'b0;
      md_op         <= 3'b000;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ctrl          <= ctrl_n;
      ctrl_valid    <= cv_n;
      illegal_instr <= ill_n;
      bus_err       <= berr_n;
      dm_req        <= req_n;
      dm_we         <= we_n;
      dm_size       <= size_n;
      md_start      <= start_n;
      md_op         <= op_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nf_seq_control_unit.sv
// ============================================================================
// tb_nf_seq_control_unit : directed self-checking bench for nf_seq_control_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nf_seq_control_unit;
  import nf_seq_control_unit_pkg::*;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_CSRRW = 32'h34001073;
  localparam logic [31:0] I_BAD   = 32'h00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, flush, instr_valid, dm_ack, md_done;
  logic [31:0] instr;
  nf_ctrl_t    ctrl;
  logic        instr_ready, ctrl_valid, illegal_instr, bus_err, dm_req, dm_we, md_start;
  logic [1:0]  dm_size;
  logic [2:0]  md_op;

  logic        instr_valid2;
  nf_ctrl_t    ctrl2;
  logic        instr_ready2, ctrl_valid2, illegal2, bus_err2, dm_req2, dm_we2, md_start2;
  logic [1:0]  dm_size2;
  logic [2:0]  md_op2;

  int checks = 0;
  int errors = 0;

  nf_seq_control_unit #(.M_EXT(1), .TIMEOUT(8), .TO_W(8)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .illegal_instr(illegal_instr), .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we),
    .dm_size(dm_size), .dm_ack(dm_ack), .md_start(md_start), .md_op(md_op), .md_done(md_done)
  );

  nf_seq_control_unit #(.M_EXT(0), .TIMEOUT(8), .TO_W(8)) u_dut_nom (
    .clk(clk), .resetn(resetn), .flush(1'b0), .instr(instr), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .ctrl(ctrl2), .ctrl_valid(ctrl_valid2),
    .illegal_instr(illegal2), .bus_err(bus_err2), .dm_req(dm_req2), .dm_we(dm_we2),
    .dm_size(dm_size2), .dm_ack(1'b0), .md_start(md_start2), .md_op(md_op2), .md_done(1'b0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; instr_valid = 1'b0; instr_valid2 = 1'b0;
    dm_ack = 1'b0; md_done = 1'b0; instr = 32'h0;
    step(); step();
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_ctrl", ctrl, '0);
    chk("rst_cv", ctrl_valid, 1'b0);
    chk("rst_req", dm_req, 1'b0);
    chk("rst_start", md_start, 1'b0);
    chk("rst_berr", bus_err, 1'b0);
    resetn = 1'b1;

    // back-to-back single-cycle ops
    instr = I_ADD; instr_valid = 1'b1;
    step();
    chk("add_cv", ctrl_valid, 1'b1);
    chk("add_alu", ctrl.alu_code, ALU_ADD);
    chk("add_we", ctrl.we_rf, 1'b1);
    chk("add_ready", instr_ready, 1'b1);
    instr = I_SUB;
    step();
    chk("sub_cv", ctrl_valid, 1'b1);
    chk("sub_alu", ctrl.alu_code, ALU_SUB);
    instr_valid = 1'b0;
    step();
    chk("idle_cv", ctrl_valid, 1'b0);

    // load, ack on the fourth wait cycle
    instr = I_LW; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("lw_ready1", instr_ready, 1'b0);
    chk("lw_req1", dm_req, 1'b1);
    chk("lw_size", dm_size, 2'b10);
    chk("lw_we", dm_we, 1'b0);
    step(); step(); step();
    chk("lw_req4", dm_req, 1'b1);
    chk("lw_cv4", ctrl_valid, 1'b0);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("lw_cv", ctrl_valid, 1'b1);
    chk("lw_req_off", dm_req, 1'b0);
    chk("lw_rfsrc", ctrl.rf_src, RF_DMEM);
    chk("lw_ready", instr_ready, 1'b1);

    // M_EXT=0 instance flags MUL illegal
    instr = I_MUL; instr_valid2 = 1'b1;
    step();
    instr_valid2 = 1'b0;
    chk("nom_ill", illegal2, 1'b1);
    chk("nom_cv", ctrl_valid2, 1'b0);
    chk("nom_we", ctrl2.we_rf, 1'b0);
    step();
    chk("nom_ill_pulse", illegal2, 1'b0);

    // MUL with done five cycles after start
    instr = I_MUL; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("mul_start", md_start, 1'b1);
    chk("mul_op", md_op, 3'b000);
    chk("mul_ready", instr_ready, 1'b0);
    step();
    chk("mul_start_pulse", md_start, 1'b0);
    step(); step(); step(); step();
    chk("mul_cv6", ctrl_valid, 1'b0);
    md_done = 1'b1;
    step();
    md_done = 1'b0;
    chk("mul_cv", ctrl_valid, 1'b1);
    chk("mul_ismd", ctrl.is_md, 1'b1);

    // md_done together with md_start
    instr = I_MUL; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    md_done = 1'b1;
    step();
    md_done = 1'b0;
    chk("mul_fast_cv", ctrl_valid, 1'b1);
    chk("mul_fast_ready", instr_ready, 1'b1);

    // store timeout
    instr = I_SW; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("sw_we", dm_we, 1'b1);
    repeat (7) step();
    chk("sw_req_last", dm_req, 1'b1);
    chk("sw_berr_early", bus_err, 1'b0);
    step();
    chk("sw_berr", bus_err, 1'b1);
    chk("sw_req_off", dm_req, 1'b0);
    chk("sw_cv", ctrl_valid, 1'b0);
    chk("sw_ready", instr_ready, 1'b1);
    step();
    chk("sw_berr_pulse", bus_err, 1'b0);

    // ack on the expiry cycle wins
    instr = I_SW; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    repeat (7) step();
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("swx_cv", ctrl_valid, 1'b1);
    chk("swx_berr", bus_err, 1'b0);

    // CSRRW with rd=x0
    instr = I_CSRRW; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("csr_cv", ctrl_valid, 1'b1);
    chk("csr_we", ctrl.we_rf, 1'b0);
    chk("csr_rreq", ctrl.csr_rreq, 1'b0);
    chk("csr_wreq", ctrl.csr_wreq, 1'b1);

    // illegal word on the main instance
    instr = I_BAD; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("bad_ill", illegal_instr, 1'b1);
    chk("bad_cv", ctrl_valid, 1'b0);
    chk("bad_ready", instr_ready, 1'b1);

    // flush during MEM
    instr = I_LW; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    flush = 1'b1;
    dm_ack = 1'b1;
    step();
    flush = 1'b0;
    dm_ack = 1'b0;
    chk("fl_ready", instr_ready, 1'b1);
    chk("fl_req", dm_req, 1'b0);
    chk("fl_cv", ctrl_valid, 1'b0);

    // flush blocks an accept in IDLE
    instr = I_SUB; instr_valid = 1'b1; flush = 1'b1;
    step();
    instr_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_cv", ctrl_valid, 1'b0);
    chk("fl_idle_ctrl", ctrl.alu_code, ALU_ADD);

    // async reset mid-MEM
    instr = I_LW; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("rm_req", dm_req, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rm_req_off", dm_req, 1'b0);
    chk("rm_ready", instr_ready, 1'b1);
    step();
    resetn = 1'b1;
    instr = I_ADD; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("rm_add_cv", ctrl_valid, 1'b1);
    chk("rm_add_alu", ctrl.alu_code, ALU_ADD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
